// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: FSM encoding, default sizes
// and a helper for word-select widths.
package spi_pkg;

    localparam int MAX_CHAR_DEF = 128;
    localparam int DIV_W_DEF    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

    // A single-word buffer still needs a 1-bit select port.
    function automatic int sel_width(input int nword);
        return (nword > 1) ? $clog2(nword) : 1;
    endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Control, buffer and SPI pin bundle for spi_shift_engine.
// go is a level request taken only in IDLE; done is a one-cycle completion pulse.
interface spi_shift_engine_if
    import spi_pkg::*;
#(
    parameter int MAX_CHAR = MAX_CHAR_DEF,
    parameter int DIV_W    = DIV_W_DEF
);
    localparam int LEN_BITS = $clog2(MAX_CHAR);
    localparam int NWORD    = MAX_CHAR / 32;
    localparam int SEL_W    = sel_width(NWORD);

    logic                go;
    logic [LEN_BITS-1:0] len;
    logic                lsb;
    logic                cpol;
    logic                cpha;
    logic [DIV_W-1:0]    divider;
    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [3:0]          byte_sel;
    logic [31:0]         p_in;
    logic [SEL_W-1:0]    rd_sel;
    logic [31:0]         p_out;
    logic                miso;
    logic                sclk_out;
    logic                mosi;
    logic                tip;
    logic                done;
    spi_state_e          state;

    modport slave (
        input  go, len, lsb, cpol, cpha, divider,
        input  wr_en, wr_sel, byte_sel, p_in, rd_sel, miso,
        output p_out, sclk_out, mosi, tip, done, state
    );

    modport master (
        output go, len, lsb, cpol, cpha, divider,
        output wr_en, wr_sel, byte_sel, p_in, rd_sel, miso,
        input  p_out, sclk_out, mosi, tip, done, state
    );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: emits a one-cycle tick every load+1 enabled clocks.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] load,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = enable && (cnt == load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine with double-buffered TX words, an RX shadow that is
// published in DONE, and a divider-timed SCLK.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int MAX_CHAR = MAX_CHAR_DEF,
    parameter int DIV_W    = DIV_W_DEF
) (
    input  logic               wb_clk_in,
    input  logic               wb_rst_n,
    spi_shift_engine_if.slave  bus
);

    localparam int LEN_BITS = $clog2(MAX_CHAR);
    localparam int NWORD    = MAX_CHAR / 32;
    localparam int SEL_W    = sel_width(NWORD);
    localparam int N_W      = LEN_BITS + 1;
    localparam int CNT_W    = LEN_BITS + 2;

    spi_state_e          state_q, state_d;
    logic [N_W-1:0]      n_q, n_new;
    logic                lsb_q, cpol_q, cpha_q;
    logic [DIV_W-1:0]    div_q;
    logic [MAX_CHAR-1:0] tx_flat, tx_shift, rx_shadow;
    logic [31:0]         tx_words [NWORD];
    logic [31:0]         rx_words [NWORD];
    logic [CNT_W-1:0]    edge_cnt, two_n;
    logic [LEN_BITS-1:0] tx_idx, rx_idx, first_idx;
    logic                sclk_q, mosi_q;
    logic                start, tick, div_en, edges_done;
    logic                odd_edge, last_edge, drive_bit, sample_bit;

    function automatic logic [LEN_BITS-1:0] step_idx(input logic [LEN_BITS-1:0] idx,
                                                     input logic up);
        return up ? idx + 1'b1 : idx - 1'b1;
    endfunction

    assign start      = (state_q == ST_IDLE) && bus.go;
    assign n_new      = (bus.len == '0) ? N_W'(MAX_CHAR) : {1'b0, bus.len};
    assign first_idx  = bus.lsb ? '0 : LEN_BITS'(n_new - 1'b1);
    assign two_n      = {n_q, 1'b0};
    assign edges_done = (edge_cnt == two_n);
    assign div_en     = (state_q == ST_SHIFT) && !edges_done;

    // edge_cnt holds edges already made, so an even count means the next edge is odd.
    assign odd_edge   = ~edge_cnt[0];
    assign last_edge  = (edge_cnt == two_n - 1'b1);
    assign drive_bit  = tick && (cpha_q ? odd_edge : (!odd_edge && !last_edge));
    assign sample_bit = tick && (cpha_q ? !odd_edge : odd_edge);

    spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk    (wb_clk_in),
        .rst_n  (wb_rst_n),
        .enable (div_en),
        .load   (div_q),
        .tick   (tick)
    );

    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus.tip   = 1'b0;
        bus.done  = 1'b0;
        bus.state = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.go) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                bus.tip = 1'b1;
                if (edges_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // TX words accept writes in every state; the snapshot on go decouples them.
    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int w = 0; w < NWORD; w++) tx_words[w] <= '0;
        end else if (bus.wr_en && ({1'b0, bus.wr_sel} < (SEL_W + 1)'(NWORD))) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byte_sel[b]) tx_words[bus.wr_sel][8*b +: 8] <= bus.p_in[8*b +: 8];
            end
        end
    end

    always_comb begin
        tx_flat = '0;
        for (int w = 0; w < NWORD; w++) tx_flat[32*w +: 32] = tx_words[w];
    end

    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            n_q       <= '0;
            lsb_q     <= 1'b0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            div_q     <= '0;
            tx_shift  <= '0;
            rx_shadow <= '0;
            edge_cnt  <= '0;
            tx_idx    <= '0;
            rx_idx    <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else if (start) begin
            n_q       <= n_new;
            lsb_q     <= bus.lsb;
            cpol_q    <= bus.cpol;
            cpha_q    <= bus.cpha;
            div_q     <= bus.divider;
            tx_shift  <= tx_flat;
            rx_shadow <= '0;
            edge_cnt  <= '0;
            rx_idx    <= first_idx;
            sclk_q    <= bus.cpol;
            if (!bus.cpha) begin
                mosi_q <= tx_flat[first_idx];
                tx_idx <= step_idx(first_idx, bus.lsb);
            end else begin
                tx_idx <= first_idx;
            end
        end else if (tick) begin
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + 1'b1;
            if (drive_bit) begin
                mosi_q <= tx_shift[tx_idx];
                tx_idx <= step_idx(tx_idx, lsb_q);
            end
            if (sample_bit) begin
                rx_shadow[rx_idx] <= bus.miso;
                rx_idx            <= step_idx(rx_idx, lsb_q);
            end
        end
    end

    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            for (int w = 0; w < NWORD; w++) rx_words[w] <= '0;
        end else if (state_q == ST_DONE) begin
            for (int w = 0; w < NWORD; w++) rx_words[w] <= rx_shadow[32*w +: 32];
        end
    end

    always_comb begin
        bus.p_out = '0;
        if ({1'b0, bus.rd_sel} < (SEL_W + 1)'(NWORD)) bus.p_out = rx_words[bus.rd_sel];
    end

    assign bus.sclk_out = sclk_q;
    assign bus.mosi     = mosi_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: timing, bit order, modes, buffering and reset abort.
module tb_spi_shift_engine;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   t0 = 0;

    bit          loopback;
    logic        miso_fix;
    int          go_hold, mid_go_at, mid_wr_at, rst_at_edge;
    logic [1:0]  mid_wr_sel;
    logic [31:0] mid_wr_data;
    logic [3:0]  mid_wr_bsel;
    int          done_at, edges, dones;

    spi_shift_engine_if #(.MAX_CHAR(128), .DIV_W(16)) bus ();

    spi_shift_engine #(.MAX_CHAR(128), .DIV_W(16)) dut (
        .wb_clk_in (clk),
        .wb_rst_n  (rst_n),
        .bus       (bus)
    );

    assign bus.miso = loopback ? bus.mosi : miso_fix;

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // driver tasks
    task automatic write_word(input logic [1:0] sel, input logic [31:0] data, input logic [3:0] bsel);
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_sel = sel;
        bus.p_in = data;
        bus.byte_sel = bsel;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic cfg(input logic [6:0] l, input logic ls, input logic cp, input logic ch,
                       input logic [15:0] d);
        bus.len = l;
        bus.lsb = ls;
        bus.cpol = cp;
        bus.cpha = ch;
        bus.divider = d;
    endtask

    task automatic start_go(input bit with_wr);
        @(negedge clk);
        bus.go = 1'b1;
        if (with_wr) begin
            bus.wr_en = 1'b1;
            bus.wr_sel = mid_wr_sel;
            bus.p_in = mid_wr_data;
            bus.byte_sel = mid_wr_bsel;
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.go = (go_hold > 1);
        t0 = cyc;
    endtask

    task automatic read_check(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        bus.rd_sel = sel;
        #1;
        check(tag, bus.p_out, exp);
    endtask

    // Runs from T0, counting SCLK edges and done pulses; bounded by limit cycles.
    task automatic run_xfer(input int limit, input int extra,
                            output int d_at, output int n_edges, output int n_dones);
        logic prev;
        int   post;
        bit   rst_taken;
        prev = bus.sclk_out;
        n_edges = 0;
        n_dones = 0;
        d_at = -1;
        post = 0;
        rst_taken = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            bus.go = (i < go_hold - 2) || (i == mid_go_at);
            bus.wr_en = (i == mid_wr_at);
            if (i == mid_wr_at) begin
                bus.wr_sel = mid_wr_sel;
                bus.p_in = mid_wr_data;
                bus.byte_sel = mid_wr_bsel;
            end
            if (bus.sclk_out != prev) n_edges++;
            prev = bus.sclk_out;
            if (bus.done) begin
                n_dones++;
                if (d_at < 0) d_at = cyc - t0;
            end
            if (n_edges == rst_at_edge && !rst_taken) begin
                rst_taken = 1'b1;
                check("pre_rst_sclk", bus.sclk_out, 1'b1);
                check("pre_rst_mosi", bus.mosi, 1'b1);
                rst_n = 1'b0;
                #1;
                check("rst_tip", bus.tip, 1'b0);
                check("rst_sclk", bus.sclk_out, 1'b0);
                check("rst_mosi", bus.mosi, 1'b0);
                check("rst_done", bus.done, 1'b0);
                check("rst_pout", bus.p_out, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                prev = bus.sclk_out;
            end
            if (d_at >= 0) begin
                post++;
                if (post > extra) break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        loopback = 1'b1;
        miso_fix = 1'b0;
        go_hold = 1;
        mid_go_at = -1;
        mid_wr_at = -1;
        rst_at_edge = -1;
        mid_wr_sel = 2'd0;
        mid_wr_data = '0;
        mid_wr_bsel = '0;
        bus.go = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_sel = '0;
        bus.byte_sel = '0;
        bus.p_in = '0;
        bus.rd_sel = '0;
        cfg(7'd0, 1'b0, 1'b0, 1'b0, 16'd0);
        repeat (3) @(negedge clk);
        check("reset_tip", bus.tip, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_sclk", bus.sclk_out, 1'b0);
        check("reset_mosi", bus.mosi, 1'b0);
        check("reset_state", bus.state, ST_IDLE);
        read_check("reset_pout", 2'd0, 32'h0);
        rst_n = 1'b1;

        // len 8, MSB first, mode 0, divider 0, loopback
        write_word(2'd0, 32'h0000_00A5, 4'hF);
        cfg(7'd8, 1'b0, 1'b0, 1'b0, 16'd0);
        start_go(1'b0);
        check("a_tip_t0", bus.tip, 1'b1);
        check("a_state_t0", bus.state, ST_SHIFT);
        check("a_mosi_t0", bus.mosi, 1'b1);
        check("a_pout_prev", bus.p_out, 32'h0);
        run_xfer(100, 2, done_at, edges, dones);
        check("a_done_at", done_at, 17);
        check("a_edges", edges, 16);
        check("a_dones", dones, 1);
        read_check("a_rx0", 2'd0, 32'h0000_00A5);
        check("a_tip_after", bus.tip, 1'b0);

        // full 128 bits, LSB first, mode 3, divider 2
        write_word(2'd0, 32'h89AB_CDEF, 4'hF);
        write_word(2'd1, 32'hFEDC_BA98, 4'hF);
        write_word(2'd2, 32'h7654_3210, 4'hF);
        write_word(2'd3, 32'h0123_4567, 4'hF);
        cfg(7'd0, 1'b1, 1'b1, 1'b1, 16'd2);
        start_go(1'b0);
        check("b_sclk_t0", bus.sclk_out, 1'b1);
        check("b_pout_prev", bus.p_out, 32'h0000_00A5);
        run_xfer(1000, 2, done_at, edges, dones);
        check("b_done_at", done_at, 769);
        check("b_edges", edges, 256);
        read_check("b_rx0", 2'd0, 32'h89AB_CDEF);
        read_check("b_rx1", 2'd1, 32'hFEDC_BA98);
        read_check("b_rx2", 2'd2, 32'h7654_3210);
        read_check("b_rx3", 2'd3, 32'h0123_4567);
        check("b_sclk_idle", bus.sclk_out, 1'b1);

        // mode 1 then mode 2, miso tied high, len 5
        loopback = 1'b0;
        miso_fix = 1'b1;
        cfg(7'd5, 1'b0, 1'b0, 1'b1, 16'd1);
        start_go(1'b0);
        check("c1_sclk_t0", bus.sclk_out, 1'b0);
        run_xfer(100, 2, done_at, edges, dones);
        check("c1_done_at", done_at, 21);
        read_check("c1_rx0", 2'd0, 32'h0000_001F);
        read_check("c1_rx1", 2'd1, 32'h0);
        check("c1_sclk_idle", bus.sclk_out, 1'b0);
        cfg(7'd5, 1'b0, 1'b1, 1'b0, 16'd0);
        start_go(1'b0);
        check("c2_sclk_t0", bus.sclk_out, 1'b1);
        run_xfer(100, 2, done_at, edges, dones);
        check("c2_done_at", done_at, 11);
        read_check("c2_rx0", 2'd0, 32'h0000_001F);
        check("c2_sclk_idle", bus.sclk_out, 1'b1);

        // TX double buffering: mid-transfer write, then write on the go cycle
        loopback = 1'b1;
        write_word(2'd0, 32'h0011_0022, 4'hF);
        cfg(7'd32, 1'b0, 1'b0, 1'b0, 16'd0);
        mid_wr_at = 10;
        mid_wr_sel = 2'd0;
        mid_wr_data = 32'hFFFF_FFFF;
        mid_wr_bsel = 4'b0101;
        start_go(1'b0);
        run_xfer(100, 2, done_at, edges, dones);
        mid_wr_at = -1;
        check("d1_done_at", done_at, 65);
        read_check("d1_rx0", 2'd0, 32'h0011_0022);
        mid_wr_data = 32'hDEAD_BEEF;
        mid_wr_bsel = 4'hF;
        start_go(1'b1);
        run_xfer(100, 2, done_at, edges, dones);
        read_check("d2_rx0", 2'd0, 32'h00FF_00FF);
        start_go(1'b0);
        run_xfer(100, 2, done_at, edges, dones);
        read_check("d3_rx0", 2'd0, 32'hDEAD_BEEF);

        // reset pulse at SCLK edge 7 of a len 16 transfer
        write_word(2'd0, 32'h0000_F000, 4'hF);
        cfg(7'd16, 1'b0, 1'b0, 1'b0, 16'd1);
        bus.rd_sel = 2'd0;
        rst_at_edge = 7;
        start_go(1'b0);
        run_xfer(100, 0, done_at, edges, dones);
        rst_at_edge = -1;
        check("e_no_done", dones, 0);
        check("e_state_idle", bus.state, ST_IDLE);
        write_word(2'd0, 32'h0000_BEEF, 4'hF);
        start_go(1'b0);
        run_xfer(100, 2, done_at, edges, dones);
        check("e_done_at", done_at, 65);
        read_check("e_rx0", 2'd0, 32'h0000_BEEF);

        // go held three cycles and re-asserted mid-transfer
        cfg(7'd8, 1'b1, 1'b0, 1'b0, 16'd0);
        go_hold = 3;
        mid_go_at = 6;
        start_go(1'b0);
        run_xfer(100, 20, done_at, edges, dones);
        go_hold = 1;
        mid_go_at = -1;
        bus.go = 1'b0;
        check("f_dones", dones, 1);
        check("f_done_at", done_at, 17);
        check("f_edges", edges, 16);
        read_check("f_rx0", 2'd0, 32'h0000_00EF);
        check("f_state_idle", bus.state, ST_IDLE);

        // report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 SHALL have parameter MAX_CHAR, default 128, meaning maximum character length in bits (32, 64, 96 or 128).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the SCLK divider.
REQ-003 SHALL derive LEN_BITS = clog2(MAX_CHAR) and NWORD = MAX_CHAR/32.
REQ-004 wb_clk_in  input  1  sole clock; one clock, all logic on its rising edge.
REQ-005 wb_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 go  input  1  start-transfer request.
REQ-007 len  input  LEN_BITS  character length; 0 means MAX_CHAR.
REQ-008 lsb  input  1  1 = LSB first, 0 = MSB first.
REQ-009 cpol, cpha  input  1 each  SPI mode.
REQ-010 divider  input  DIV_W  SCLK half-period = divider+1 clocks.
REQ-011 wr_en, wr_sel, byte_sel, p_in  input  1, clog2(NWORD), 4, 32  byte-enabled TX buffer write.
REQ-012 rd_sel  input  clog2(NWORD)  RX word select; p_out  output  32  selected RX word, combinational.
REQ-013 miso  input  1; sclk_out, mosi  output  1 each, registered.
REQ-014 tip  output  1  transfer in progress; done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL use FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on go; SHIFT->DONE after edge 2N; DONE->IDLE unconditionally.
REQ-016 On go in IDLE SHALL snapshot len, lsb, cpol, cpha and divider; SHALL copy tx_buf into the shift register; N = (len==0 ? MAX_CHAR : len).
REQ-017 go while tip=1 or in DONE SHALL be ignored; snapshot values SHALL NOT change mid-transfer.
REQ-018 tip SHALL be 1 from the cycle after go (T0) until DONE; sclk_out SHALL toggle at T0+k*(divider+1), k=1..2N.
REQ-019 done=1 and tip=0 SHALL occur at T0+2N*(divider+1)+1; done SHALL last exactly one cycle.
REQ-020 Bit order: lsb=1 sends/receives bit 0 first, ascending; lsb=0 sends bit N-1 first, descending.
REQ-021 cpha=0: first bit on mosi at T0; sample on odd (leading) edges; drive next bit on even edges except after the last bit.
REQ-022 cpha=1: drive on odd edges; sample on even edges.
REQ-023 sclk_out SHALL equal the snapshotted cpol in IDLE and SHALL end at cpol after edge 2N.
REQ-024 mosi SHALL hold its last value between transfers.
REQ-025 Received bits SHALL land in rx shadow bits [N-1:0]; bits N..MAX_CHAR-1 SHALL be 0.
REQ-026 rx_buf SHALL update from the shadow only in DONE; p_out SHALL show the previous result during a transfer.
REQ-027 TX buffer writes SHALL be accepted in any state (double buffering); only bytes with byte_sel set change.
REQ-028 A write in the same cycle as an accepted go SHALL NOT affect that transfer, only the next.
REQ-029 Out-of-range wr_sel/rd_sel (NWORD not a power of two) SHALL ignore the write and read 0.

Reset
REQ-030 Assertion of wb_rst_n=0 SHALL immediately abort any transfer: state IDLE, tip=0, done=0, mosi=0, sclk_out=0, tx_buf=0, rx_buf=0, divider counter=0.
REQ-031 The first go after reset release SHALL behave as in REQ-016.

Structure
REQ-032 FSM state encodings and the MAX_CHAR/DIV_W defaults SHALL live in shared package spi_pkg.
REQ-033 The half-period counter and tick generation SHALL be sub-module spi_clk_div (inputs: enable, load value; output: one-cycle tick).
REQ-034 Implementation SHALL be synthesizable, with no latches and no derived clocks.

Verification
REQ-035 MAX_CHAR=128, len=8, lsb=0, mode 0, divider=0, tx word0=0xA5, miso looped to mosi: 16 edges; done at T0+17; p_out(rd_sel=0)=0x000000A5.
REQ-036 len=0, lsb=1, mode 3, divider=2, tx=128-bit pattern 0x0123...CDEF, loopback: 256 edges; done at T0+769; all four words match tx.
REQ-037 Mode 1 vs mode 2 with miso tied to 1, len=5: rx word0=0x0000001F in both; sclk_out idle level = cpol.
REQ-038 wr_en with p_in=0xFFFFFFFF, byte_sel=4'b0101 issued mid-transfer: current transfer unaffected; next transfer sends 0x00FF00FF in the low word.
REQ-039 wb_rst_n pulsed low at edge 7 of a len=16 transfer: tip=0, sclk_out=0, mosi=0 immediately; no done pulse; next go completes normally.
REQ-040 go held high for 3 cycles and re-asserted during the transfer: exactly one transfer and one done pulse.
